// File: rtl/instruction_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one word fetch at a time
// over a req/gnt/rvalid handshake and presents the result to IF/ID.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        PCWrite,
    input  logic        Branch,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemGnt,
    input  logic        ImemRValid,
    input  logic [31:0] ImemRData,
    output logic [31:0] OutInstruction,
    output logic [31:0] OutPCAddResult,
    output logic        OutValid,
    output logic [31:0] PCOut
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] pc4_q;
    logic        valid_q;

    logic        redir;
    logic [31:0] redir_pc;
    logic [31:0] pc_inc;

    // Branch wins over Jump; targets are forced word-aligned.
    assign redir    = Branch | Jump;
    assign redir_pc = (Branch ? BranchTarget : JumpTarget) & 32'hFFFF_FFFC;
    assign pc_inc   = pc_q + 32'd4;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (redir) begin
                        pc_q <= redir_pc;
                        // A grant on the redirect edge fetched the old PC.
                        if (ImemGnt) state_q <= S_DROP;
                    end else if (ImemGnt) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redir) begin
                        pc_q    <= redir_pc;
                        state_q <= ImemRValid ? S_REQ : S_DROP;
                    end else if (ImemRValid) begin
                        instr_q <= ImemRData;
                        pc4_q   <= pc_inc;
                        valid_q <= 1'b1;
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (redir) begin
                        pc_q    <= redir_pc;
                        instr_q <= 32'd0;
                        valid_q <= 1'b0;
                        state_q <= S_REQ;
                    end else if (PCWrite) begin
                        pc_q    <= pc_inc;
                        instr_q <= 32'd0;
                        valid_q <= 1'b0;
                        state_q <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (redir) pc_q <= redir_pc;
                    // A response arriving with the redirect still retires the stale fetch.
                    if (ImemRValid) state_q <= S_REQ;
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

    assign ImemReq        = (state_q == S_REQ) & Rst;
    assign ImemAddr       = pc_q;
    assign PCOut          = pc_q;
    assign OutInstruction = instr_q;
    assign OutPCAddResult = pc4_q;
    assign OutValid       = valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed plus randomized check of instruction_fetch_unit against a
// transaction-level model of the fetch front end.
module tb_instruction_fetch_unit;

    logic        Clk = 1'b0;
    logic        Rst, PCWrite, Branch, Jump, ImemGnt, ImemRValid;
    logic [31:0] BranchTarget, JumpTarget, ImemRData;
    logic        ImemReq, OutValid;
    logic [31:0] ImemAddr, OutInstruction, OutPCAddResult, PCOut;

    logic        w_rst, w_pcw, w_gnt, w_rv;
    logic [31:0] w_rd;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_pc4, w_pcout;

    int vectors = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0040)) u_dut (
        .Clk(Clk), .Rst(Rst), .PCWrite(PCWrite),
        .Branch(Branch), .BranchTarget(BranchTarget),
        .Jump(Jump), .JumpTarget(JumpTarget),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemGnt(ImemGnt),
        .ImemRValid(ImemRValid), .ImemRData(ImemRData),
        .OutInstruction(OutInstruction), .OutPCAddResult(OutPCAddResult),
        .OutValid(OutValid), .PCOut(PCOut)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .Clk(Clk), .Rst(w_rst), .PCWrite(w_pcw),
        .Branch(1'b0), .BranchTarget(32'd0),
        .Jump(1'b0), .JumpTarget(32'd0),
        .ImemReq(w_req), .ImemAddr(w_addr), .ImemGnt(w_gnt),
        .ImemRValid(w_rv), .ImemRData(w_rd),
        .OutInstruction(w_instr), .OutPCAddResult(w_pc4),
        .OutValid(w_valid), .PCOut(w_pcout)
    );

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0] ^ 16'h1357, a[31:16]} ^ 32'h9E37_79B9;
    endfunction

    // Model: where the PC is, whether a fetch is outstanding, whether that
    // fetch is on the wrong path, and whether an instruction is presented.
    logic [31:0] m_pc = 32'h40, m_instr = 32'd0, m_pc4 = 32'd0;
    logic        m_busy = 1'b0, m_wrong = 1'b0, m_pres = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ImemReq", {31'd0, ImemReq}, {31'd0, Rst & ~m_pres & ~m_busy});
        chk("ImemAddr", ImemAddr, m_pc);
        chk("PCOut", PCOut, m_pc);
        chk("OutValid", {31'd0, OutValid}, {31'd0, m_pres});
        chk("OutInstruction", OutInstruction, m_pres ? m_instr : 32'd0);
        if (m_pres) chk("OutPCAddResult", OutPCAddResult, m_pc4);
    endtask

    task automatic model_edge();
        logic        rd;
        logic [31:0] tgt;
        rd  = Branch | Jump;
        tgt = (Branch ? BranchTarget : JumpTarget) & ~32'd3;
        if (!Rst) begin
            m_pc = 32'h40; m_busy = 0; m_wrong = 0; m_pres = 0;
            m_instr = 0; m_pc4 = 0;
        end else if (m_pres) begin
            if (rd || PCWrite) begin
                m_pc   = rd ? tgt : m_pc + 32'd4;
                m_pres = 0;
            end
        end else if (m_busy) begin
            if (ImemRValid) begin
                m_busy = 0;
                if (!rd && !m_wrong) begin
                    m_pres  = 1;
                    m_instr = memfn(m_pc);
                    m_pc4   = m_pc + 32'd4;
                end
                if (rd) m_pc = tgt;
                m_wrong = 0;
            end else if (rd) begin
                m_pc    = tgt;
                m_wrong = 1;
            end
        end else begin
            if (ImemGnt) begin
                m_busy  = 1;
                m_wrong = rd;
            end
            if (rd) m_pc = tgt;
        end
    endtask

    // Called at a negedge: check, drive, update model, advance one cycle.
    task automatic step(input logic rst, input logic pcw,
                        input logic br, input logic [31:0] bt,
                        input logic jp, input logic [31:0] jt,
                        input logic gnt, input logic rv, input logic [31:0] rdata);
        check_all();
        Rst = rst; PCWrite = pcw; Branch = br; BranchTarget = bt;
        Jump = jp; JumpTarget = jt; ImemGnt = gnt; ImemRValid = rv; ImemRData = rdata;
        model_edge();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    initial begin
        Rst = 0; PCWrite = 0; Branch = 0; Jump = 0; BranchTarget = 0; JumpTarget = 0;
        ImemGnt = 0; ImemRValid = 0; ImemRData = 0;
        w_rst = 0; w_pcw = 0; w_gnt = 0; w_rv = 0; w_rd = 0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);

        // Reset release and first fetch from 0x40.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("first_req", {31'd0, ImemReq}, 32'd1);
        chk("first_addr", ImemAddr, 32'h40);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, memfn(32'h40));
        chk("first_instr", OutInstruction, memfn(32'h40));
        chk("first_pc4", OutPCAddResult, 32'h44);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("second_addr", ImemAddr, 32'h44);

        // Stall four cycles in the presented state.
        step(1, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, memfn(32'h44));
        repeat (4) step(1, 0, 0, 0, 0, 0, 1, 1, 32'hBAD0_BAD0);
        chk("stall_instr", OutInstruction, memfn(32'h44));
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("post_stall_addr", ImemAddr, 32'h48);

        // Jump while waiting; stale word arrives three cycles later.
        step(1, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1, 32'h200, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("drop_valid", {31'd0, OutValid}, 32'd0);
        chk("drop_next_addr", ImemAddr, 32'h200);

        // Branch and Jump together in hold with PCWrite=0: Branch wins.
        step(1, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, memfn(32'h200));
        step(1, 0, 1, 32'h103, 1, 32'h300, 0, 0, 0);
        chk("br_jp_valid", {31'd0, OutValid}, 32'd0);
        chk("br_jp_instr", OutInstruction, 32'd0);
        chk("br_jp_addr", ImemAddr, 32'h100);

        // Reset in S_WAIT.
        step(1, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_wait_pc", PCOut, 32'h40);
        chk("rst_wait_req", {31'd0, ImemReq}, 32'd0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_wait_addr", ImemAddr, 32'h40);

        // Reset in S_HOLD.
        step(1, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, memfn(32'h40));
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_hold_valid", {31'd0, OutValid}, 32'd0);
        chk("rst_hold_instr", OutInstruction, 32'd0);
        chk("rst_hold_pc4", OutPCAddResult, 32'd0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_hold_addr", ImemAddr, 32'h40);

        // Randomized traffic against a variable-latency memory.
        mem_busy = 0; mem_cnt = 0; mem_addr = 0;
        for (int i = 0; i < 2000; i++) begin
            logic        r_rst, r_rv, r_br, r_jp, r_gnt, req_now;
            logic [31:0] r_rd;
            r_rst = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            r_rv  = 0; r_rd = $urandom;
            if (mem_busy && mem_cnt == 0) begin
                r_rv = 1; r_rd = memfn(mem_addr);
            end else if (!m_busy && $urandom_range(0, 9) == 0) begin
                r_rv = 1;
            end
            r_br  = ($urandom_range(0, 99) < 8);
            r_jp  = ($urandom_range(0, 99) < 8);
            if (m_busy && m_wrong && r_rv) begin
                r_br = 0; r_jp = 0;
            end
            r_gnt   = ($urandom_range(0, 99) < 60);
            req_now = r_rst & ~m_pres & ~m_busy;
            if (!r_rst) begin
                mem_busy = 0;
            end else begin
                if (mem_busy && mem_cnt == 0) mem_busy = 0;
                else if (mem_busy) mem_cnt--;
                if (req_now && r_gnt) begin
                    mem_busy = 1;
                    mem_cnt  = $urandom_range(0, 2);
                    mem_addr = ImemAddr;
                end
            end
            step(r_rst, $urandom_range(0, 1) == 1, r_br, $urandom, r_jp, $urandom,
                 r_gnt, r_rv, r_rd);
        end
        check_all();

        // PC wrap on a second instance reset to 0xFFFF_FFFC.
        w_rst = 1; w_gnt = 0;
        #1;
        chk("wrap_req", {31'd0, w_req}, 32'd1);
        chk("wrap_addr", w_addr, 32'hFFFF_FFFC);
        w_gnt = 1;
        @(posedge Clk); @(negedge Clk);
        w_gnt = 0; w_rv = 1; w_rd = memfn(32'hFFFF_FFFC);
        @(posedge Clk); @(negedge Clk);
        w_rv = 0;
        chk("wrap_valid", {31'd0, w_valid}, 32'd1);
        chk("wrap_instr", w_instr, memfn(32'hFFFF_FFFC));
        chk("wrap_pc4", w_pc4, 32'd0);
        w_pcw = 1;
        @(posedge Clk); @(negedge Clk);
        w_pcw = 0;
        chk("wrap_next_req", {31'd0, w_req}, 32'd1);
        chk("wrap_next_addr", w_addr, 32'd0);
        chk("wrap_pcout", w_pcout, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
